// File: rtl/ctrl_fsm_pkg.sv
// rtl/ctrl_fsm_pkg.sv - shared opcode, state, op-class and ALU select definitions for ctrl_fsm
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NAND  = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_BEQ   = 4'hB,
    OP_BNE   = 4'hC,
    OP_BLT   = 4'hD,
    OP_BGE   = 4'hE,
    OP_HALT  = 4'hF
  } op_e;

  typedef enum logic [4:0] {
    ST_INIT    = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_LOAD_A  = 5'd3,
    ST_LOAD_B  = 5'd4,
    ST_STORE   = 5'd5,
    ST_EXEC    = 5'd6,
    ST_BR_CMP  = 5'd7,
    ST_BR_TAKE = 5'd8,
    ST_HALT    = 5'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOOP   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_ALU    = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_HALT   = 3'd5
  } op_cls_e;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NAND = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_SHR  = 4'd8;

endpackage

// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - controller <-> datapath signal bundle; slave = ctrl_fsm, master = datapath side
interface ctrl_fsm_if #(
  parameter int RAW  = 4,
  parameter int DAW  = 8,
  parameter int CNTW = 16
);
  localparam int IW = 4 + RAW + DAW;

  logic            Run;
  logic [IW-1:0]   IR;
  logic            ALU_Z;
  logic            ALU_N;
  logic            PC_CLR;
  logic            IR_LD;
  logic            PC_IC;
  logic            PC_REL;
  logic [RAW-1:0]  PC_OFS;
  logic [DAW-1:0]  D_ADDR;
  logic            D_WR;
  logic            RF_S;
  logic            RF_W_EN;
  logic [RAW-1:0]  RF_A_ADDR;
  logic [RAW-1:0]  RF_B_ADDR;
  logic [RAW-1:0]  RF_W_ADDR;
  logic [3:0]      ALU_S;
  logic            Halted;
  logic [CNTW-1:0] Retired;

  modport slave (
    input  Run, IR, ALU_Z, ALU_N,
    output PC_CLR, IR_LD, PC_IC, PC_REL, PC_OFS, D_ADDR, D_WR, RF_S, RF_W_EN,
           RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted, Retired
  );

  modport master (
    output Run, IR, ALU_Z, ALU_N,
    input  PC_CLR, IR_LD, PC_IC, PC_REL, PC_OFS, D_ADDR, D_WR, RF_S, RF_W_EN,
           RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted, Retired
  );
endinterface

// File: rtl/ctrl_fsm_decode.sv
// rtl/ctrl_fsm_decode.sv - combinational IR field slicing and op classification (CTRL_FSM_BRANCH_EN)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int RAW = 4,
  parameter int DAW = 8
) (
  input  logic [4+RAW+DAW-1:0] i_ir,
  output op_cls_e              o_cls,
`ifdef CTRL_FSM_BRANCH_EN
  output op_e                  o_op,
`endif
  output logic [RAW-1:0]       o_ra,
  output logic [RAW-1:0]       o_rb,
  output logic [RAW-1:0]       o_lo,
  output logic [DAW-1:0]       o_laddr,
  output logic [DAW-1:0]       o_saddr,
  output logic [3:0]           o_alu_s
);
  localparam int IW = 4 + RAW + DAW;

  op_e w_op;

  assign w_op    = op_e'(i_ir[IW-1 -: 4]);
  assign o_ra    = i_ir[IW-5 -: RAW];
  assign o_rb    = i_ir[IW-5-RAW -: RAW];
  assign o_lo    = i_ir[RAW-1:0];
  assign o_laddr = i_ir[IW-5 -: DAW];
  assign o_saddr = i_ir[DAW-1:0];
`ifdef CTRL_FSM_BRANCH_EN
  assign o_op    = w_op;
`endif

  always_comb begin
    o_cls = CLS_NOOP;
    case (w_op)
      OP_LOAD:  o_cls = CLS_LOAD;
      OP_STORE: o_cls = CLS_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_SHL, OP_SHR:
        o_cls = CLS_ALU;
`ifdef CTRL_FSM_BRANCH_EN
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
        o_cls = CLS_BRANCH;
`endif
      OP_HALT:  o_cls = CLS_HALT;
      default:  o_cls = CLS_NOOP;
    endcase
  end

  // ALU opcodes 3..A map onto ALU_S 1..8
  assign o_alu_s = (o_cls == CLS_ALU) ? (w_op - 4'd2) : 4'd0;

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle fetch/decode/execute control unit with retired counter (CTRL_FSM_BRANCH_EN)
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int RAW  = 4,
  parameter int DAW  = 8,
  parameter int CNTW = 16
) (
  input logic     Clock,
  input logic     Reset,
  ctrl_fsm_if.slave bus
);
  state_e          r_state;
  state_e          w_next;
  logic            w_retire;
  logic [CNTW-1:0] r_retired;

  op_cls_e         w_cls;
  logic [RAW-1:0]  w_ra;
  logic [RAW-1:0]  w_rb;
  logic [RAW-1:0]  w_lo;
  logic [DAW-1:0]  w_laddr;
  logic [DAW-1:0]  w_saddr;
  logic [3:0]      w_alu_s;

`ifdef CTRL_FSM_BRANCH_EN
  op_e             w_op;
  logic            w_taken;
`else
  logic            w_unused_flags;
  assign w_unused_flags = bus.ALU_Z ^ bus.ALU_N;
`endif

  ctrl_decode #(.RAW(RAW), .DAW(DAW)) u_decode (
    .i_ir    (bus.IR),
    .o_cls   (w_cls),
`ifdef CTRL_FSM_BRANCH_EN
    .o_op    (w_op),
`endif
    .o_ra    (w_ra),
    .o_rb    (w_rb),
    .o_lo    (w_lo),
    .o_laddr (w_laddr),
    .o_saddr (w_saddr),
    .o_alu_s (w_alu_s)
  );

`ifdef CTRL_FSM_BRANCH_EN
  // Flags come from ra - rb computed combinationally while in BR_CMP
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BEQ:  w_taken = bus.ALU_Z;
      OP_BNE:  w_taken = !bus.ALU_Z;
      OP_BLT:  w_taken = bus.ALU_N;
      OP_BGE:  w_taken = !bus.ALU_N;
      default: w_taken = 1'b0;
    endcase
  end
`endif

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      ST_INIT:   if (bus.Run) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_cls)
          CLS_LOAD:   w_next = ST_LOAD_A;
          CLS_STORE:  w_next = ST_STORE;
          CLS_ALU:    w_next = ST_EXEC;
`ifdef CTRL_FSM_BRANCH_EN
          CLS_BRANCH: w_next = ST_BR_CMP;
`endif
          CLS_HALT: begin
            w_next   = ST_HALT;
            w_retire = 1'b1;
          end
          default: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      ST_LOAD_A: w_next = ST_LOAD_B;
      ST_LOAD_B, ST_STORE, ST_EXEC: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
`ifdef CTRL_FSM_BRANCH_EN
      ST_BR_CMP: begin
        w_next   = w_taken ? ST_BR_TAKE : ST_FETCH;
        w_retire = !w_taken;
      end
      ST_BR_TAKE: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
`endif
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_INIT;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire && (r_retired != {CNTW{1'b1}}))
        r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    bus.PC_CLR    = 1'b0;
    bus.IR_LD     = 1'b0;
    bus.PC_IC     = 1'b0;
    bus.PC_REL    = 1'b0;
    bus.PC_OFS    = '0;
    bus.D_ADDR    = '0;
    bus.D_WR      = 1'b0;
    bus.RF_S      = 1'b0;
    bus.RF_W_EN   = 1'b0;
    bus.RF_A_ADDR = '0;
    bus.RF_B_ADDR = '0;
    bus.RF_W_ADDR = '0;
    bus.ALU_S     = 4'd0;
    bus.Halted    = 1'b0;
    case (r_state)
      ST_INIT:   bus.PC_CLR = 1'b1;
      ST_FETCH:  bus.IR_LD  = 1'b1;
      ST_DECODE: bus.PC_IC  = 1'b1;
      ST_LOAD_A, ST_LOAD_B: begin
        bus.D_ADDR    = w_laddr;
        bus.RF_S      = 1'b1;
        bus.RF_W_ADDR = w_lo;
        bus.RF_W_EN   = (r_state == ST_LOAD_B);
      end
      ST_STORE: begin
        bus.RF_A_ADDR = w_ra;
        bus.D_ADDR    = w_saddr;
        bus.D_WR      = 1'b1;
      end
      ST_EXEC: begin
        bus.RF_A_ADDR = w_ra;
        bus.RF_B_ADDR = w_rb;
        bus.RF_W_ADDR = w_lo;
        bus.RF_W_EN   = 1'b1;
        bus.ALU_S     = w_alu_s;
      end
`ifdef CTRL_FSM_BRANCH_EN
      ST_BR_CMP: begin
        bus.RF_A_ADDR = w_ra;
        bus.RF_B_ADDR = w_rb;
        bus.ALU_S     = ALU_SUB;
      end
      ST_BR_TAKE: begin
        bus.PC_REL = 1'b1;
        bus.PC_OFS = w_lo;
      end
`endif
      ST_HALT:   bus.Halted = 1'b1;
      default:   bus.PC_CLR = 1'b0;
    endcase
  end

  assign bus.Retired = r_retired;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm (expectations follow CTRL_FSM_BRANCH_EN)
module tb_ctrl_fsm;
  localparam int RAW  = 4;
  localparam int DAW  = 8;
  localparam int CNTW = 4;

  logic Clock;
  logic Reset;
  int   n_assert;
  int   n_fail;
  logic [3:0]  exp_ret;
  logic [35:0] w_obs;
  logic [35:0] e_init, e_fetch, e_dec, e_halt;

  ctrl_fsm_if #(.RAW(RAW), .DAW(DAW), .CNTW(CNTW)) bus ();

  ctrl_fsm #(.RAW(RAW), .DAW(DAW), .CNTW(CNTW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign w_obs = {bus.PC_CLR, bus.IR_LD, bus.PC_IC, bus.PC_REL, bus.PC_OFS, bus.D_ADDR,
                  bus.D_WR, bus.RF_S, bus.RF_W_EN, bus.RF_A_ADDR, bus.RF_B_ADDR,
                  bus.RF_W_ADDR, bus.ALU_S, bus.Halted};

  function automatic logic [35:0] mk(input logic pc_clr, input logic ir_ld, input logic pc_ic,
                                     input logic pc_rel, input logic [3:0] ofs,
                                     input logic [7:0] da, input logic dwr, input logic rfs,
                                     input logic wen, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] w, input logic [3:0] alu,
                                     input logic hlt);
    return {pc_clr, ir_ld, pc_ic, pc_rel, ofs, da, dwr, rfs, wen, a, b, w, alu, hlt};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] exp);
    n_assert++;
    assert (w_obs === exp) else begin
      n_fail++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, w_obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    n_assert++;
    assert (bus.Retired === exp_ret) else begin
      n_fail++;
      $error("FAIL %s Retired observed=%h expected=%h", tag, bus.Retired, exp_ret);
    end
  endtask

  task automatic retire();
    if (exp_ret != 4'hF) exp_ret = exp_ret + 4'd1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_ret  = 4'd0;
    e_init  = mk(1,0,0,0,4'h0,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,0);
    e_fetch = mk(0,1,0,0,4'h0,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,0);
    e_dec   = mk(0,0,1,0,4'h0,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,0);
    e_halt  = mk(0,0,0,0,4'h0,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,1);

    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.IR = 16'h0000;
    bus.ALU_Z = 1'b0;
    bus.ALU_N = 1'b0;
    step();
    step();
    Reset = 1'b0;
    chk("reset_init", e_init);
    chk_ret("reset_retired");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_init", e_init);
    end

    bus.Run = 1'b1;
    step();
    bus.Run = 1'b0;
    chk("run_fetch", e_fetch);

    // ADD r1,r2 -> r5
    bus.IR = 16'h3125;
    step(); chk("add_decode", e_dec);
    step(); chk("add_exec", mk(0,0,0,0,4'h0,8'h00,0,0,1,4'h1,4'h2,4'h5,4'h1,0));
    chk_ret("add_retired_pre");
    step(); chk("add_fetch", e_fetch);
    retire(); chk_ret("add_retired");

    // LOAD [A7] -> r3
    bus.IR = 16'h1A73;
    step(); chk("load_decode", e_dec);
    step(); chk("load_a", mk(0,0,0,0,4'h0,8'hA7,0,1,0,4'h0,4'h0,4'h3,4'h0,0));
    step(); chk("load_b", mk(0,0,0,0,4'h0,8'hA7,0,1,1,4'h0,4'h0,4'h3,4'h0,0));
    step(); chk("load_fetch", e_fetch);
    retire(); chk_ret("load_retired");

    // STORE r5 -> [C3]
    bus.IR = 16'h25C3;
    step(); chk("store_decode", e_dec);
    step(); chk("store_exec", mk(0,0,0,0,4'h0,8'hC3,1,0,0,4'h5,4'h0,4'h0,4'h0,0));
    step(); chk("store_fetch", e_fetch);
    retire(); chk_ret("store_retired");

    // BEQ r1,r2,-2 with Z=1 then Z=0
    bus.IR = 16'hB12E;
    bus.ALU_Z = 1'b1;
    step(); chk("beq_t_decode", e_dec);
`ifdef CTRL_FSM_BRANCH_EN
    step(); chk("beq_t_cmp", mk(0,0,0,0,4'h0,8'h00,0,0,0,4'h1,4'h2,4'h0,4'h2,0));
    chk_ret("beq_t_retired_pre");
    step(); chk("beq_t_take", mk(0,0,0,1,4'hE,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,0));
`endif
    step(); chk("beq_t_fetch", e_fetch);
    retire(); chk_ret("beq_t_retired");

    bus.ALU_Z = 1'b0;
    step(); chk("beq_n_decode", e_dec);
`ifdef CTRL_FSM_BRANCH_EN
    step(); chk("beq_n_cmp", mk(0,0,0,0,4'h0,8'h00,0,0,0,4'h1,4'h2,4'h0,4'h2,0));
`endif
    step(); chk("beq_n_fetch", e_fetch);
    retire(); chk_ret("beq_n_retired");

    // BLT r3,r4,+5 with N=1
    bus.IR = 16'hD345;
    bus.ALU_N = 1'b1;
    step(); chk("blt_decode", e_dec);
`ifdef CTRL_FSM_BRANCH_EN
    step(); chk("blt_cmp", mk(0,0,0,0,4'h0,8'h00,0,0,0,4'h3,4'h4,4'h0,4'h2,0));
    step(); chk("blt_take", mk(0,0,0,1,4'h5,8'h00,0,0,0,4'h0,4'h0,4'h0,4'h0,0));
`endif
    step(); chk("blt_fetch", e_fetch);
    retire(); chk_ret("blt_retired");
    bus.ALU_N = 1'b0;

    // HALT, held with Run toggling
    bus.IR = 16'hF000;
    step(); chk("halt_decode", e_dec);
    step(); chk("halt_enter", e_halt);
    retire(); chk_ret("halt_retired");
    for (int i = 0; i < 20; i++) begin
      bus.Run = i[0];
      step();
      chk("halt_hold", e_halt);
    end
    chk_ret("halt_retired_hold");
    bus.Run = 1'b0;

    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_ret = 4'd0;
    chk("halt_reset_init", e_init);
    chk_ret("halt_reset_retired");

    // reset in the middle of a LOAD
    bus.Run = 1'b1;
    step(); chk("mid_fetch", e_fetch);
    bus.Run = 1'b0;
    bus.IR = 16'h1A73;
    step(); chk("mid_decode", e_dec);
    step(); chk("mid_load_a", mk(0,0,0,0,4'h0,8'hA7,0,1,0,4'h0,4'h0,4'h3,4'h0,0));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_reset_init", e_init);
    step(); chk("mid_reset_stay", e_init);
    chk_ret("mid_reset_retired");

    // Reset wins over Run in the same cycle
    Reset = 1'b1;
    bus.Run = 1'b1;
    step();
    Reset = 1'b0;
    bus.Run = 1'b0;
    chk("rst_run_init", e_init);
    step(); chk("rst_run_stay", e_init);

    // 20 NOOPs: Retired saturates at 4'hF
    bus.Run = 1'b1;
    step(); chk("sat_fetch0", e_fetch);
    bus.Run = 1'b0;
    bus.IR = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      step(); chk("sat_decode", e_dec);
      step(); chk("sat_fetch", e_fetch);
      retire(); chk_ret("sat_retired");
    end
    n_assert++;
    assert (exp_ret === 4'hF) else begin
      n_fail++;
      $error("FAIL sat_model observed=%h expected=%h", exp_ret, 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
